// File: rtl/md_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Latency: mult/div results appear 33 cycles after the accepting edge; mthi/mtlo update HI/LO one cycle later.
// Backpressure: a start is taken only in IDLE/DONE and ignored while busy is high, so the core must stall on busy.
// Ports: clk, rst (async active-low), start/op/a/b request, busy/done status, hi/lo registers.
module md_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;   // {upper half, lower half}: product/accumulator or {remainder, dividend->quotient}
  logic [31:0] r_b;     // multiplicand or divisor magnitude
  logic        r_div;
  logic        r_sa;
  logic        r_sb;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept;
  logic        w_iter;
  logic        w_mthi;
  logic        w_mtlo;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_nxt;
  logic [32:0] w_rem_sh;
  logic [32:0] w_trial;
  logic [63:0] w_div_nxt;
  logic [63:0] w_step;
  logic        w_neg;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_last;

  assign w_accept = start && (r_state != S_CALC);
  assign w_iter   = w_accept && !op[2];
  assign w_mthi   = w_accept && (op == 3'b100);
  assign w_mtlo   = w_accept && (op == 3'b101);

  // op[0]==0 selects the signed variants (mult, div)
  assign w_a_neg  = !op[0] && a[31];
  assign w_b_neg  = !op[0] && b[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - a) : a;
  assign w_b_mag  = w_b_neg ? (32'd0 - b) : b;

  // Shift-add: add multiplicand to the upper half when the current multiplier
  // bit (LSB) is set, then shift the whole 65-bit value right by one.
  assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
  assign w_mul_nxt = {w_mul_sum, r_acc[31:1]};

  // Restoring step: shift next dividend bit into the remainder and keep the
  // trial difference only when it is non-negative. A zero divisor naturally
  // yields quotient all-ones and remainder equal to the dividend.
  assign w_rem_sh  = {r_acc[63:32], r_acc[31]};
  assign w_trial   = w_rem_sh - {1'b0, r_b};
  assign w_div_nxt = w_trial[32] ? {w_rem_sh[31:0], r_acc[30:0], 1'b0}
                                 : {w_trial[31:0],  r_acc[30:0], 1'b1};

  assign w_step = r_div ? w_div_nxt : w_mul_nxt;

  // Sign flags are latched as zero for unsigned ops, so no correction happens there.
  assign w_neg  = r_sa ^ r_sb;
  assign w_prod = w_neg ? (64'd0 - w_step) : w_step;
  assign w_quo  = w_neg ? (32'd0 - w_step[31:0]) : w_step[31:0];
  assign w_rem  = r_sa  ? (32'd0 - w_step[63:32]) : w_step[63:32];
  assign w_last = (r_state == S_CALC) && (r_cnt == 5'd31);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: w_next = w_iter ? S_CALC : S_IDLE;
      S_CALC: begin
        busy = 1'b1;
        if (r_cnt == 5'd31) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = w_iter ? S_CALC : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 5'd0;
      r_acc <= 64'd0;
      r_b   <= 32'd0;
      r_div <= 1'b0;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
    end else if (w_iter) begin
      // Same initial layout serves both datapaths: lower half holds |a|.
      r_cnt <= 5'd0;
      r_acc <= {32'd0, w_a_mag};
      r_b   <= w_b_mag;
      r_div <= op[1];
      r_sa  <= w_a_neg;
      r_sb  <= w_b_neg;
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + 5'd1;
      r_acc <= w_step;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_last) begin
      if (r_div) begin
        r_hi <= w_rem;
        r_lo <= w_quo;
      end else begin
        r_hi <= w_prod[63:32];
        r_lo <= w_prod[31:0];
      end
    end else begin
      if (w_mthi) r_hi <= a;
      if (w_mtlo) r_lo <= a;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors;
  int checks;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  md_unit dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Scoreboard monitor: every done pulse consumes one expected {hi,lo}.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (hi=%h lo=%h)", hi, lo);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result_hi", hi, mon_e[63:32]);
        chk("result_lo", lo, mon_e[31:0]);
      end
    end
  end

  // Drive a request on the next sampling edge, then scramble operands.
  task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 32'hDEADBEEF;
    b     = 32'h0BAD0BAD;
  endtask

  // Called right after the accepting edge: busy for 32 cycles with hi/lo
  // frozen, then done in the 33rd. Optionally pokes an mthi mid-calc.
  task automatic check_calc(input int poke);
    logic [31:0] h0;
    logic [31:0] l0;
    int bad;
    bad = 0;
    h0  = 32'd0;
    l0  = 32'd0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == 1) begin
        h0 = hi;
        l0 = lo;
      end
      if (!busy || done || hi !== h0 || lo !== l0) bad++;
      if (i == poke) begin
        start = 1'b1;
        op    = 3'b100;
        a     = 32'h55555555;
      end else if (i == poke + 1) begin
        start = 1'b0;
      end
    end
    chk("busy_window_bad_cycles", 32'(bad), 32'd0);
    @(negedge clk);
    chk("done_busy_at_T33", {30'd0, done, busy}, 32'd2);
  endtask

  initial begin
    int dcount;
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    start  = 1'b0;
    op     = 3'b000;
    a      = 32'd0;
    b      = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // multu max*max
    @(posedge clk); #1;
    exp_q.push_back({32'hFFFFFFFE, 32'h00000001});
    start_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check_calc(0);

    // mult -3*7, then div -7/2 issued in the DONE cycle
    @(posedge clk); #1;
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFEB});
    start_op(3'b000, 32'hFFFFFFFD, 32'd7);
    check_calc(0);
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    start_op(3'b010, 32'hFFFFFFF9, 32'd2);
    check_calc(0);

    // divide by zero cases and the overflow corner
    @(posedge clk); #1;
    exp_q.push_back({32'h00000064, 32'hFFFFFFFF});
    start_op(3'b011, 32'd100, 32'd0);
    check_calc(0);
    @(posedge clk); #1;
    exp_q.push_back({32'hFFFFFFFB, 32'h00000001});
    start_op(3'b010, 32'hFFFFFFFB, 32'd0);
    check_calc(0);
    @(posedge clk); #1;
    exp_q.push_back({32'h00000000, 32'h80000000});
    start_op(3'b010, 32'h80000000, 32'hFFFFFFFF);
    check_calc(0);

    // mthi then mtlo on consecutive edges, first one accepted from DONE
    start = 1'b1;
    op    = 3'b100;
    a     = 32'h12345678;
    @(posedge clk); #1;
    op    = 3'b101;
    a     = 32'h9ABCDEF0;
    @(negedge clk);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy_done", {30'd0, busy, done}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_hi_kept", hi, 32'h12345678);
    chk("mtlo_busy_done", {30'd0, busy, done}, 32'd0);

    // divu 1000/7 with an mthi attempt during CALC that must be ignored
    @(posedge clk); #1;
    exp_q.push_back({32'd6, 32'd142});
    start_op(3'b011, 32'd1000, 32'd7);
    check_calc(5);

    // asynchronous reset in the middle of a multiply
    @(posedge clk); #1;
    start_op(3'b000, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("abort_no_activity", 32'(dcount), 32'd0);

    // multu after reset, then an undefined op issued from DONE
    @(posedge clk); #1;
    exp_q.push_back({32'd0, 32'd30});
    start_op(3'b001, 32'd5, 32'd6);
    check_calc(0);
    start = 1'b1;
    op    = 3'b111;
    a     = 32'hCAFEF00D;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("undef_busy_done", {30'd0, busy, done}, 32'd0);
    chk("undef_hi", hi, 32'd0);
    chk("undef_lo", lo, 32'd30);

    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
